result_register_bank: RTL

Parametrised successor to the fixed 10×16 result register file. Holds DEPTH result words of DATA_W bits with a per-entry valid bit. Supports overwrite or saturating-accumulate writes, asynchronous-style random read, and a global clear. Adds a drain engine that streams every valid entry out over a valid/ready handshake, optionally consuming each entry as it goes. Sits between the compute datapath (writer) and the output/transmit logic (reader).

---
 rtl/result_register_bank.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/result_register_bank.sv
// result_register_bank
// ---------------------
// Bank of DEPTH result words of DATA_W bits. Each entry has a valid bit.
// A write either overwrites the entry or adds to it with saturation.
// A drain engine sweeps the bank and streams each valid entry out over a
// valid/ready handshake. It can optionally consume each entry as it goes.
//
// Ports
//   clk          rising-edge system clock
//   n_rst        asynchronous active-low reset
//   w_enable     write strobe
//   w_mode       0 = overwrite, 1 = saturating accumulate
//   in_sel       write address (ignored when >= DEPTH)
//   in_data      write data
//   clear_data   synchronous clear of the whole bank; also aborts a drain
//   out_sel      random read address
//   out_data     combinational read data (0 when out_sel >= DEPTH)
//   out_valid    combinational valid bit of out_sel
//   drain_start  start a sweep (honoured only while idle)
//   drain_valid  drain_addr/drain_data hold an entry being offered
//   drain_ready  consumer accepts the offered entry
//   drain_addr   address of the offered entry
//   drain_data   data of the offered entry (snapshot taken when found)
//   drain_busy   drain engine not idle
//   drain_done   one-cycle pulse at the end of a completed sweep
module result_register_bank #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 10,
    parameter int ADDR_W         = 4,
    parameter int CLEAR_ON_DRAIN = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              w_enable,
    input  logic              w_mode,
    input  logic [ADDR_W-1:0] in_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear_data,
    input  logic [ADDR_W-1:0] out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              drain_start,
    output logic              drain_valid,
    input  logic              drain_ready,
    output logic [ADDR_W-1:0] drain_addr,
    output logic [DATA_W-1:0] drain_data,
    output logic              drain_busy,
    output logic              drain_done
);

    typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} drain_state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SAT_MAX  = '1;

    logic [DATA_W-1:0] entry [DEPTH];
    logic [DEPTH-1:0]  valid;

    drain_state_t      state;
    drain_state_t      next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] next_idx;
    logic              load_present;
    logic              write_hit;
    logic              drain_take;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;

    // The sum is formed at DATA_W+1 bits so that a carry out means saturation.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? SAT_MAX : sum[DATA_W-1:0];
    endfunction

    assign write_hit  = w_enable && ({1'b0, in_sel} < DEPTH_W);
    assign drain_take = (state == PRESENT) && drain_ready;

    // The muxes for the read port and for the scan index compare each entry
    // against the address. An address past DEPTH matches no entry and so
    // reads as 0/invalid.
    always_comb begin
        out_data   = '0;
        out_valid  = 1'b0;
        scan_data  = '0;
        scan_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (out_sel == ADDR_W'(i)) begin
                out_data  = entry[i];
                out_valid = valid[i];
            end
            if (idx == ADDR_W'(i)) begin
                scan_data  = entry[i];
                scan_valid = valid[i];
            end
        end
    end

    // Storage. A clear takes priority over everything else. A write to the
    // entry that is being handed off on the same edge takes priority over the
    // consume-on-drain, so the new value survives.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            valid <= '0;
        end else if (clear_data) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_hit && (in_sel == ADDR_W'(i))) begin
                    entry[i] <= (w_mode && valid[i]) ? sat_add(entry[i], in_data) : in_data;
                    valid[i] <= 1'b1;
                end else if ((CLEAR_ON_DRAIN != 0) && drain_take && (idx == ADDR_W'(i))) begin
                    entry[i] <= '0;
                    valid[i] <= 1'b0;
                end
            end
        end
    end

    // Drain next-state logic. SCAN inspects one entry per cycle. PRESENT
    // holds a snapshot until the consumer takes it. A clear aborts the sweep
    // without a done pulse.
    always_comb begin
        next_state   = state;
        next_idx     = idx;
        load_present = 1'b0;
        if (clear_data) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        next_idx   = '0;
                        next_state = SCAN;
                    end
                end
                SCAN: begin
                    if (scan_valid) begin
                        load_present = 1'b1;
                        next_state   = PRESENT;
                    end else if (idx == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        next_idx = idx + 1'b1;
                    end
                end
                PRESENT: begin
                    if (drain_ready) begin
                        if (idx == LAST_IDX) begin
                            next_state = DONE;
                        end else begin
                            next_idx   = idx + 1'b1;
                            next_state = SCAN;
                        end
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Drain state register and presented-word snapshot.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            idx        <= '0;
            drain_addr <= '0;
            drain_data <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            if (load_present) begin
                drain_addr <= idx;
                drain_data <= scan_data;
            end
        end
    end

    assign drain_valid = (state == PRESENT);
    assign drain_busy  = (state != IDLE);
    assign drain_done  = (state == DONE);

endmodule
